cnt_key_ctrl: RTL and testbench
===============================

Name: cnt_key_ctrl

Overview:
- Pushbutton front end that drives the enable and clear inputs of the 3-digit BCD counter top level.
- Synchronises and debounces two raw active-low DE10 keys (start/stop, clear).
- Edge-detects the debounced presses and runs an IDLE/RUN/PAUSE/CLEAR state machine.
- Outputs are levels, because the downstream counter samples them on its slow divided clock. Single-cycle pulses would be missed.

Parameters:
- DB_CNT, 1_000_000, consecutive clk cycles a synchronised key level must hold before the debounced level changes (20 ms at 50 MHz); legal range >= 1.
- CLR_MIN, 50_000_000, minimum clk cycles clr stays asserted once entered (1 s at 50 MHz, ≥ one divided-clock period); legal range >= 1.

Ports:
- clk  input  1  system clock (50 MHz board clock).
- rst  input  1  reset; asynchronous, active-low.
- key_run_n  input  1  raw start/stop pushbutton, active-low, asynchronous to clk.
- key_clr_n  input  1  raw clear pushbutton, active-low, asynchronous to clk.
- en  output  1  count enable to the counter; high only in RUN.
- clr  output  1  counter clear level; high only in CLEAR.
- state_o  output  2  current state for LEDs: 0 IDLE, 1 RUN, 2 PAUSE, 3 CLEAR.

Behaviour:
- Reset (rst low, async) forces:
  - sync flops and debounced levels = 1 (released);
  - debounce and hold counters = 0; press pulses = 0;
  - state = IDLE; en = 0; clr = 0; state_o = 0.
- Reset asserted mid-operation takes effect immediately, with no completion of a pending CLEAR.
- Synchroniser: 2-flop per key, kept separate from the debouncer.
- Debouncer, one per key:
  - The counter increments while the synced level differs from the debounced level. It resets to 0 when they are equal.
  - When the counter reaches DB_CNT-1 and the levels still differ, the debounced level takes the synced level on that edge and the counter clears.
  - Counter width is $clog2(DB_CNT+1).
  - Bounces shorter than DB_CNT cycles produce no change.
- Press detect: registered pulse press_x = db_prev & ~db, one clk wide, one per debounced falling edge. Releases generate nothing.
- Latency: raw key low, sampled at edge 1, gives en/clr change visible after edge DB_CNT+4. Breakdown: 2 sync + DB_CNT debounce + 1 pulse register + 1 state register.
- FSM (Moore outputs; en = state==RUN, clr = state==CLEAR):
  - IDLE: press_run -> RUN. press_clr -> CLEAR.
  - RUN: press_run -> PAUSE. press_clr -> CLEAR.
  - PAUSE: press_run -> RUN. press_clr -> CLEAR.
  - CLEAR: hold counter counts from 0 on entry. Exit to IDLE when hold count >= CLR_MIN-1 AND the debounced clr key is released (1). press_run is ignored in CLEAR.
- Simultaneous press_run and press_clr in the same cycle: clr wins and the state goes to CLEAR.
- A press_clr while already in CLEAR does not restart the hold counter.
- A key held low through reset release registers as one press after DB_CNT+3 cycles, because the debounced level starts at 1.
- No other outputs toggle while a key is held. One press equals exactly one transition.

Test Plan (DB_CNT=4, CLR_MIN=8):
- Reset, then key_run_n low for 20 cycles -> en rises exactly 8 cycles after the first sampling edge; state_o=1. Release -> no change. A second press -> en=0, state_o=2.
- key_run_n glitch low for 3 cycles, then high -> en, clr and state_o unchanged. A 4-cycle low -> press registered.
- In RUN, key_clr_n low for 2 cycles after debounce (released quickly) -> clr=1, en=0 for exactly 8 cycles. Then clr=0, state_o=0.
- In PAUSE, hold key_clr_n low for 30 cycles -> clr stays 1 until the debounced release. IDLE is reached the cycle after the release is debounced, not at the 8-cycle hold minimum.
- Both keys driven low on the same cycle from IDLE -> state_o=3, en never 1.
- In RUN, pull rst low asynchronously mid-cycle -> en=0 and state_o=0 immediately, before the next clk edge. On release, with no keys pressed, the block stays IDLE.

Source files
------------

// File: rtl/cnt_key_ctrl.sv
// Pushbutton front end for the BCD counter: syncs and debounces the run/clear keys,
// then turns debounced presses into level enable/clear outputs via a small FSM.
module cnt_key_ctrl #(
  parameter int DB_CNT  = 1_000_000,
  parameter int CLR_MIN = 50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_run_n,
  input  logic       key_clr_n,
  output logic       en,
  output logic       clr,
  output logic [1:0] state_o
);

  // state | meaning
  // IDLE  | stopped, counter holds its value
  // RUN   | counting (en high)
  // PAUSE | stopped after a run, waiting for resume
  // CLEAR | clr held high for at least CLR_MIN cycles and until the clr key is released
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    CLEAR = 2'd3
  } state_t;

  localparam int DW = $clog2(DB_CNT + 1);
  localparam int HW = $clog2(CLR_MIN + 1);

  // Bit 0 carries the run key, bit 1 the clear key.
  logic [1:0]    key_raw;
  logic [1:0]    sync1;
  logic [1:0]    sync2;
  logic [1:0]    db;
  logic [1:0]    db_prev;
  logic [1:0]    press;
  logic [DW-1:0] db_cnt [2];
  logic [HW-1:0] hold;
  state_t        state;

  assign key_raw = {key_clr_n, key_run_n};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= 2'b11;
      sync2 <= 2'b11;
    end else begin
      sync1 <= key_raw;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      db <= 2'b11;
      for (int k = 0; k < 2; k++) db_cnt[k] <= '0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (sync2[k] == db[k]) begin
          db_cnt[k] <= '0;
        end else if (db_cnt[k] == DW'(DB_CNT - 1)) begin
          db[k]     <= sync2[k];
          db_cnt[k] <= '0;
        end else begin
          db_cnt[k] <= db_cnt[k] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      db_prev <= 2'b11;
      press   <= 2'b00;
    end else begin
      db_prev <= db;
      press   <= db_prev & ~db;
    end
  end

  // Clear has priority over run, so a simultaneous press always lands in CLEAR.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      hold  <= '0;
      en    <= 1'b0;
      clr   <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          if (hold == HW'(CLR_MIN - 1) && db[1]) begin
            state <= IDLE;
            en    <= 1'b0;
            clr   <= 1'b0;
          end else if (hold != HW'(CLR_MIN - 1)) begin
            hold <= hold + 1'b1;
          end
        end
        default: begin
          if (press[1]) begin
            state <= CLEAR;
            hold  <= '0;
            en    <= 1'b0;
            clr   <= 1'b1;
          end else if (press[0]) begin
            if (state == RUN) begin
              state <= PAUSE;
              en    <= 1'b0;
            end else begin
              state <= RUN;
              en    <= 1'b1;
            end
          end
        end
      endcase
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_cnt_key_ctrl.sv
// Bench for cnt_key_ctrl: directed key sequences plus random key activity,
// compared every cycle with a sliding-window reference model of the key front end.
module tb_cnt_key_ctrl;

  localparam int DB   = 4;
  localparam int CM   = 8;
  localparam int MAXN = 4096;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       key_run_n = 1'b1;
  logic       key_clr_n = 1'b1;
  logic       en;
  logic       clr;
  logic [1:0] state_o;

  always #5 clk = ~clk;

  cnt_key_ctrl #(.DB_CNT(DB), .CLR_MIN(CM)) dut (
    .clk       (clk),
    .rst       (rst),
    .key_run_n (key_run_n),
    .key_clr_n (key_clr_n),
    .en        (en),
    .clr       (clr),
    .state_o   (state_o)
  );

  int checks = 0;
  int passed = 0;

  // Per-edge history since the last reset release; index 0 is the reset state.
  bit samp [2][MAXN];
  bit dbh  [2][MAXN];
  bit fall [2][MAXN];
  int n     = 0;
  int st    = 0;
  int entry = 0;
  bit en_seen = 1'b0;

  task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    checks++;
    assert (obs === exp) begin
      passed = passed + 1;
    end else begin
      $error("FAIL %s observed=%0d expected=%0d (edge %0d)", tag, obs, exp, n);
    end
  endtask

  function automatic bit sget(input int k, input int i);
    return (i < 1) ? 1'b1 : samp[k][i];
  endfunction

  task automatic model_reset();
    n     = 0;
    st    = 0;
    entry = 0;
    for (int k = 0; k < 2; k++) begin
      dbh[k][0]  = 1'b1;
      fall[k][0] = 1'b0;
    end
  endtask

  // The debounced level at edge n follows a key only if the raw samples that reached
  // the debouncer over the last DB edges (raw delayed by the 2 sync stages) all agree.
  task automatic model_edge();
    bit v, ok, prev, pr, pc;
    if (n >= MAXN - 1) begin
      $display("FAIL model_overflow observed=%0d expected<%0d", n, MAXN - 1);
      $fatal(1, "model history exhausted");
    end
    n++;
    samp[0][n] = key_run_n;
    samp[1][n] = key_clr_n;
    for (int k = 0; k < 2; k++) begin
      prev = dbh[k][n-1];
      v    = sget(k, n - 2);
      ok   = 1'b1;
      for (int j = n - 1 - DB; j <= n - 2; j++)
        if (sget(k, j) != v) ok = 1'b0;
      dbh[k][n]  = (ok && v != prev) ? v : prev;
      fall[k][n] = prev & ~dbh[k][n];
    end
    pr = (n >= 3) ? fall[0][n-2] : 1'b0;
    pc = (n >= 3) ? fall[1][n-2] : 1'b0;
    if (st == 3) begin
      if ((n - entry) >= CM && dbh[1][n-1]) st = 0;
    end else if (pc) begin
      st    = 3;
      entry = n;
    end else if (pr) begin
      st = (st == 1) ? 2 : 1;
    end
  endtask

  task automatic step(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      @(posedge clk);
      model_edge();
      #1;
      chk("state_o", state_o, 2'(st));
      chk("en", {1'b0, en}, {1'b0, st == 1});
      chk("clr", {1'b0, clr}, {1'b0, st == 3});
      if (en) en_seen = 1'b1;
    end
  endtask

  initial begin
    #1 rst = 1'b0;
    #2;
    chk("rst_state", state_o, 2'd0);
    chk("rst_en", {1'b0, en}, 2'd0);
    chk("rst_clr", {1'b0, clr}, 2'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    model_reset();

    // Run press latency, release, then pause.
    key_run_n = 1'b0;
    step(7);
    chk("run_lat_before", {1'b0, en}, 2'd0);
    step(1);
    chk("run_lat_at", {1'b0, en}, 2'd1);
    chk("run_state", state_o, 2'd1);
    step(12);
    key_run_n = 1'b1;
    step(10);
    chk("release_no_change", state_o, 2'd1);
    key_run_n = 1'b0;
    step(8);
    chk("pause_state", state_o, 2'd2);
    chk("pause_en", {1'b0, en}, 2'd0);
    key_run_n = 1'b1;
    step(10);

    // Short glitch ignored, DB-long press accepted.
    key_run_n = 1'b0;
    step(3);
    key_run_n = 1'b1;
    step(10);
    chk("glitch_ignored", state_o, 2'd2);
    key_run_n = 1'b0;
    step(4);
    key_run_n = 1'b1;
    step(10);
    chk("min_press", state_o, 2'd1);

    // Quick clear from RUN: clr high for exactly CM cycles.
    key_clr_n = 1'b0;
    step(7);
    key_clr_n = 1'b1;
    step(1);
    chk("clr_first", {1'b0, clr}, 2'd1);
    chk("clr_first_en", {1'b0, en}, 2'd0);
    step(7);
    chk("clr_last", {1'b0, clr}, 2'd1);
    step(1);
    chk("clr_done", {1'b0, clr}, 2'd0);
    chk("clr_done_state", state_o, 2'd0);
    step(10);

    // Held clear from PAUSE: exit waits for the debounced release.
    key_run_n = 1'b0; step(8);
    key_run_n = 1'b1; step(10);
    key_run_n = 1'b0; step(8);
    key_run_n = 1'b1; step(10);
    chk("pause_again", state_o, 2'd2);
    key_clr_n = 1'b0;
    step(30);
    chk("clr_held", {1'b0, clr}, 2'd1);
    key_clr_n = 1'b1;
    step(6);
    chk("clr_before_release", {1'b0, clr}, 2'd1);
    step(1);
    chk("clr_after_release", state_o, 2'd0);
    step(10);

    // Both keys together: clear wins, en never rises.
    en_seen   = 1'b0;
    key_run_n = 1'b0;
    key_clr_n = 1'b0;
    step(8);
    chk("both_state", state_o, 2'd3);
    key_run_n = 1'b1;
    key_clr_n = 1'b1;
    step(20);
    chk("both_no_en", {1'b0, en_seen}, 2'd0);
    chk("both_idle", state_o, 2'd0);

    // Asynchronous reset while running.
    key_run_n = 1'b0; step(8);
    key_run_n = 1'b1; step(10);
    chk("pre_rst_run", state_o, 2'd1);
    #3 rst = 1'b0;
    #1;
    chk("async_rst_en", {1'b0, en}, 2'd0);
    chk("async_rst_state", state_o, 2'd0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    model_reset();
    step(15);
    chk("post_rst_idle", state_o, 2'd0);

    // Run key held low through reset release.
    #3 rst = 1'b0;
    key_run_n = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    model_reset();
    step(DB + 3);
    chk("held_rst_pre", state_o, 2'd0);
    step(1);
    chk("held_rst_run", state_o, 2'd1);
    key_run_n = 1'b1;
    step(10);

    // Random key activity against the model.
    for (int i = 0; i < 60; i++) begin
      key_run_n = ($urandom_range(0, 2) != 0);
      key_clr_n = ($urandom_range(0, 5) != 0);
      step($urandom_range(1, 14));
    end
    key_run_n = 1'b1;
    key_clr_n = 1'b1;
    step(30);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
